// File: rtl/mem_responder_if.sv
// Request/response bus between the core's load/store port and mem_responder.
// master = core side, slave = memory side.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Handshaked word RAM responder with WAIT_CYCLES wait states and byte-enabled writes.
// Optional MISALIGN_ERR_EN: misaligned requests return rsp_err=1 and never touch the RAM.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} stateT;

    stateT           stateQ, stateD;
    logic [7:0]      waitCntQ, waitCntD;
    logic            weQ;
    logic [AW-1:0]   idxQ;
    logic [31:0]     wdataQ;
    logic [3:0]      beQ;
    logic [31:0]     rdataQ;
    logic            errQ;
    logic            accept;
    logic            doAccess;
    logic            misalign;
    logic [31:0]     mem [DEPTH_WORDS];

`ifdef MISALIGN_ERR_EN
    logic [1:0] offQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            offQ <= 2'b00;
        end else if (accept) begin
            offQ <= bus.req_addr[1:0];
        end
    end

    assign misalign = (offQ != 2'b00);
    logic unusedAddrBits;
    assign unusedAddrBits = ^bus.req_addr[31:AW+2];
`else
    assign misalign = 1'b0;
    logic unusedAddrBits;
    assign unusedAddrBits = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
`endif

    always_comb begin
        stateD   = stateQ;
        waitCntD = waitCntQ;
        accept   = 1'b0;
        doAccess = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (bus.req_valid) begin
                    accept   = 1'b1;
                    waitCntD = 8'(WAIT_CYCLES);
                    stateD   = StAccess;
                end
            end
            StAccess: begin
                if (waitCntQ != 8'd0) begin
                    waitCntD = waitCntQ - 8'd1;
                end else begin
                    doAccess = 1'b1;
                    stateD   = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ   <= StIdle;
            waitCntQ <= 8'd0;
        end else begin
            stateQ   <= stateD;
            waitCntQ <= waitCntD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weQ    <= 1'b0;
            idxQ   <= '0;
            wdataQ <= 32'd0;
            beQ    <= 4'd0;
        end else if (accept) begin
            weQ    <= bus.req_we;
            idxQ   <= bus.req_addr[AW+1:2];
            wdataQ <= bus.req_wdata;
            beQ    <= bus.req_be;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdataQ <= 32'd0;
            errQ   <= 1'b0;
        end else if (doAccess) begin
            errQ   <= misalign;
            rdataQ <= (weQ || misalign) ? 32'd0 : mem[idxQ];
        end
    end

    // RAM has no reset; a reset before counter-zero keeps doAccess low, so no commit.
    always_ff @(posedge clk) begin
        if (doAccess && weQ && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (beQ[i]) begin
                    mem[idxQ][8*i +: 8] <= wdataQ[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (stateQ == StIdle);
    assign bus.rsp_valid = (stateQ == StResp);
    assign bus.rsp_rdata = rdataQ;
    assign bus.rsp_err   = errQ;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic against
// an associative-array memory model. Honours MISALIGN_ERR_EN when defined.
module tb_mem_responder;
    localparam int unsigned DepthWords = 1024;
    localparam int unsigned WaitCycles = 2;

    logic clk;
    logic rst;
    int   vecCnt;
    int   errCnt;

    logic [31:0] model [int];

    mem_responder_if bus ();

    mem_responder #(
        .DEPTH_WORDS (DepthWords),
        .WAIT_CYCLES (WaitCycles)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idxOf(input logic [31:0] addr);
        return int'((addr >> 2) % DepthWords);
    endfunction

    function automatic bit errExpected(input logic [31:0] addr);
`ifdef MISALIGN_ERR_EN
        return addr[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Runs one transaction; stall = cycles of rsp backpressure, with a stray req_valid pulse.
    task automatic runTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int stall, input bit earlyReady,
                          output logic [31:0] rdata, output logic err);
        int edges;
        checkVal("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.rsp_ready = earlyReady;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_we    = $urandom_range(0, 1);
        bus.req_be    = 4'($urandom);
        edges = 0;
        while (!bus.rsp_valid && edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
        end
        bus.rsp_ready = 1'b0;
        checkVal("latency", 32'(edges), 32'(WaitCycles + 1));
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        for (int s = 0; s < stall; s++) begin
            bus.req_valid = (s == 0);
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            checkVal("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkVal("stall_rdata", bus.rsp_rdata, rdata);
            checkVal("stall_err", 32'(bus.rsp_err), 32'(err));
            checkVal("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checkVal("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkVal("post_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    // Runs a transaction and compares against the model, then updates the model.
    task automatic modelTxn(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be, input int stall,
                            input bit earlyReady);
        logic [31:0] rdata;
        logic        err;
        logic [31:0] word;
        bit          eErr;
        int          idx;
        idx  = idxOf(addr);
        eErr = errExpected(addr);
        runTxn(we, addr, wdata, be, stall, earlyReady, rdata, err);
        checkVal({tag, "_err"}, 32'(err), 32'(eErr));
        if (eErr || we) begin
            checkVal({tag, "_rdata0"}, rdata, 32'd0);
        end else if (model.exists(idx)) begin
            checkVal({tag, "_rdata"}, rdata, model[idx]);
        end
        if (we && !eErr) begin
            word = model.exists(idx) ? model[idx] : 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
            end
            if (be != 4'd0 || model.exists(idx)) model[idx] = word;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        vecCnt        = 0;
        errCnt        = 0;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_be    = 4'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checkVal("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkVal("rst_rdata", bus.rsp_rdata, 32'd0);
        checkVal("rst_err", 32'(bus.rsp_err), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full write/read, partial write, be=0 write
        modelTxn("wr_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        runTxn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
        checkVal("rd_full", rd, 32'hDEADBEEF);
        checkVal("rd_full_err", 32'(er), 32'd0);
        modelTxn("wr_part", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, 1'b0);
        runTxn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
        checkVal("rd_part", rd, 32'hDEADBEAA);
        modelTxn("wr_be0", 1'b1, 32'h10, 32'h11223344, 4'b0000, 0, 1'b0);
        runTxn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
        checkVal("rd_be0", rd, 32'hDEADBEAA);

        // Backpressure with a stray request pulse
        modelTxn("rd_stall", 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0);

        // Aliasing
        modelTxn("wr_alias", 1'b1, 32'h1000, 32'h12345678, 4'hF, 0, 1'b0);
        runTxn(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, er);
        checkVal("rd_alias", rd, 32'h12345678);

        // Misaligned read
        runTxn(1'b0, 32'h11, 32'h0, 4'h0, 0, 1'b0, rd, er);
`ifdef MISALIGN_ERR_EN
        checkVal("mis_err", 32'(er), 32'd1);
        checkVal("mis_rdata", rd, 32'd0);
        runTxn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
        checkVal("mis_after", rd, 32'hDEADBEAA);
`else
        checkVal("mis_err", 32'(er), 32'd0);
        checkVal("mis_rdata", rd, 32'hDEADBEAA);
`endif

        // Reset during ACCESS aborts the write
        modelTxn("wr_zero20", 1'b1, 32'h20, 32'h0, 4'hF, 0, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hCAFEF00D;
        bus.req_be    = 4'hF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        #2;
        checkVal("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkVal("abort_req_ready", 32'(bus.req_ready), 32'd1);
        #2;
        rst = 1'b1;
        repeat (WaitCycles + 2) begin
            @(posedge clk);
            #1;
            checkVal("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        runTxn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er);
        checkVal("abort_rd", rd, 32'h0);

        // Random traffic against the model
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15) + 64) << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
            modelTxn("rand", 1'($urandom), a, $urandom, 4'($urandom),
                     $urandom_range(0, 3), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle RISC-V core's load/store port. It accepts one request at a time over a valid/ready request channel and models a configurable number of wait states. It performs word reads and byte-enabled writes on an internal word-addressed RAM, then returns the result over a valid/ready response channel. It replaces the single-cycle unified instruction/data memory when the core is driven through a handshaked bus.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two; AW = clog2(DEPTH_WORDS).
- WAIT_CYCLES, 2: extra access-stage cycles; legal range 0..255.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables; bit i enables req_wdata[8i+7:8i]; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  read data; 0 for writes and errored accesses.
- rsp_err  out  1  access error (see Configuration).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - latch we, addr, wdata, be;
  - load wait counter with WAIT_CYCLES;
  - go to ACCESS.
- ACCESS: req_ready=0.
  - Counter nonzero: decrement, stay.
  - Counter zero: perform the access and go to RESP.
  - A read registers mem[idx] into rsp_rdata.
  - A write updates only the enabled bytes of mem[idx] and clears rsp_rdata to 0.
- RESP: rsp_valid=1, holding rsp_rdata/rsp_err stable. On rsp_ready, go to IDLE. rsp_valid stays high until accepted.
- Word index idx = latched addr[AW+1:2]. Address bits above AW+1 are ignored, so addresses alias modulo DEPTH_WORDS*4.
- Write with req_be=0: RAM unchanged; a normal response is still returned.
- No request overlap: a new request is accepted only after the previous response handshake. Req inputs in ACCESS/RESP are ignored.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
- Reset is asynchronous; assertion mid-ACCESS aborts the request. A write that has not yet reached counter-zero is not committed, and no response is produced.
- Latency: request accepted at edge N. rsp_valid rises after edge N+1+WAIT_CYCLES.
  - WAIT_CYCLES=0: accepted at edge N, rsp_valid high after edge N+1.
- Response accepted at edge M: rsp_valid=0 and req_ready=1 after edge M. The earliest next request acceptance is edge M+1.
- Back-to-back throughput: one transaction per WAIT_CYCLES+3 cycles with rsp_ready held high.
- rsp_ready high while rsp_valid=0 has no effect.

## Configuration
- MISALIGN_ERR_EN defined:
  - A request with latched addr[1:0]!=0 completes with rsp_err=1 and rsp_rdata=0.
  - For writes, the RAM is not modified.
  - Latency is unchanged.
- MISALIGN_ERR_EN undefined: addr[1:0] is ignored (access goes to the containing word), and rsp_err is constant 0.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10. Read response rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid rises exactly WAIT_CYCLES+1 edges after each acceptance.
- Partial write: write 0x000000AA to 0x10 with be=4'b0001, then read 0x10 -> 0xDEADBEAA. Write 0x11223344 with be=0, then read -> 0xDEADBEAA.
- Backpressure: hold rsp_ready=0 for 5 cycles during a read response. rsp_valid and rsp_rdata stay stable and req_ready stays 0; a req_valid pulse during this window is not accepted.
- Aliasing with DEPTH_WORDS=1024: write 0x12345678 to 0x1000, then read 0x0000 -> 0x12345678.
- Misaligned read of 0x11:
  - MISALIGN_ERR_EN defined: rsp_err=1, rsp_rdata=0, and a subsequent aligned read of 0x10 returns prior contents.
  - Macro undefined: rsp_err=0, returns word at 0x10.
- Drive rst low during ACCESS of a write of 0xCAFEF00D to 0x20, before the counter reaches zero. After release, rsp_valid=0 and req_ready=1. A read of 0x20 does not return 0xCAFEF00D when 0x20 was previously written with 0x0.
